// File: rtl/busy_scoreboard_pkg.sv
// Shared sizing for the register busy scoreboard: default select width and
// the derived register count / pending-counter width.
package busy_scoreboard_pkg;

    localparam int unsigned SEL_W_DEF = 3;

    function automatic int unsigned nreg_f(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    // Counter must hold 0..NREG inclusive, hence one bit wider than the select.
    function automatic int unsigned cnt_w_f(input int unsigned sel_w);
        return sel_w + 32'd1;
    endfunction

endpackage

// File: rtl/busy_scoreboard_decoder_n.sv
// SEL_W-to-2^SEL_W one-hot decoder with enable; all-zero output when disabled.
module decoder_n
    import busy_scoreboard_pkg::*;
#(
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic                  en_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [2**SEL_W-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/busy_scoreboard.sv
// Register busy scoreboard: tracks outstanding writes per architectural register
// and holds the decode stage on RAW/WAW hazards against the registered busy mask.
module busy_scoreboard
    import busy_scoreboard_pkg::*;
#(
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter bit          ZERO_RO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  iss_vld_i,
    input  logic [SEL_W-1:0]      iss_dst_i,
    input  logic                  src1_vld_i,
    input  logic [SEL_W-1:0]      src1_i,
    input  logic                  src2_vld_i,
    input  logic [SEL_W-1:0]      src2_i,
    input  logic                  wb_vld_i,
    input  logic [SEL_W-1:0]      wb_dst_i,
    output logic                  stall_o,
    output logic                  iss_ack_o,
    output logic [2**SEL_W-1:0]   busy_o,
    output logic [SEL_W:0]        pend_cnt_o,
    output logic                  err_o
);

    localparam int unsigned NREG  = nreg_f(SEL_W);
    localparam int unsigned CNT_W = cnt_w_f(SEL_W);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NREG);
    localparam logic [NREG-1:0]  RO_MASK = ZERO_RO ? ~{{(NREG-1){1'b0}}, 1'b1}
                                                   : {NREG{1'b1}};

    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [NREG-1:0]  busy_eff;
    logic [NREG-1:0]  iss_onehot;
    logic [NREG-1:0]  iss_mask;
    logic [NREG-1:0]  wb_mask;
    logic             src1_haz, src2_haz, dst_haz;
    logic             stall, iss_ack;
    logic             iss_set, wb_hit, wb_bad, wb_is_r0;

    // Register 0 reads as never busy when it is hard-wired read-only.
    assign busy_eff = busy_q & RO_MASK;

    assign src1_haz = src1_vld_i & busy_eff[src1_i];
    assign src2_haz = src2_vld_i & busy_eff[src2_i];
    assign dst_haz  = iss_vld_i  & busy_eff[iss_dst_i];
    assign stall    = src1_haz | src2_haz | dst_haz;
    assign iss_ack  = iss_vld_i & ~stall;

    decoder_n #(
        .SEL_W    (SEL_W)
    ) u_iss_dec (
        .en_i     (iss_ack),
        .sel_i    (iss_dst_i),
        .onehot_o (iss_onehot)
    );

    decoder_n #(
        .SEL_W    (SEL_W)
    ) u_wb_dec (
        .en_i     (wb_vld_i),
        .sel_i    (wb_dst_i),
        .onehot_o (wb_mask)
    );

    assign iss_mask = iss_onehot & RO_MASK;
    assign iss_set  = |iss_mask;
    assign wb_hit   = |(wb_mask & busy_eff);
    assign wb_is_r0 = ZERO_RO && (wb_dst_i == '0);
    assign wb_bad   = wb_vld_i & ~busy_eff[wb_dst_i] & ~wb_is_r0;

    always_comb begin
        busy_d = ((busy_eff & ~wb_mask) | iss_mask) & RO_MASK;
        cnt_d  = cnt_q;
        err_d  = err_q | wb_bad;

        // Issue and a freeing writeback in the same cycle leave the count unchanged.
        if (iss_set && !wb_hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!iss_set && wb_hit && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (flush_i) begin
            busy_d = '0;
            cnt_d  = '0;
            err_d  = err_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign stall_o    = stall;
    assign iss_ack_o  = iss_ack;
    assign busy_o     = busy_eff;
    assign pend_cnt_o = cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_busy_scoreboard.sv
// Scoreboard bench for busy_scoreboard: two instances (ZERO_RO=0 and ZERO_RO=1)
// driven in lockstep, checked against an array-based register model.
module tb_busy_scoreboard;

    localparam int SW = 3;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, iss_vld, src1_vld, src2_vld, wb_vld;
    logic [SW-1:0] iss_dst, src1, src2, wb_dst;

    logic [1:0]         stall, ack, err;
    logic [1:0][NR-1:0] busy;
    logic [1:0][SW:0]   cnt;

    busy_scoreboard #(.SEL_W(SW), .ZERO_RO(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .iss_vld_i(iss_vld), .iss_dst_i(iss_dst),
        .src1_vld_i(src1_vld), .src1_i(src1),
        .src2_vld_i(src2_vld), .src2_i(src2),
        .wb_vld_i(wb_vld), .wb_dst_i(wb_dst),
        .stall_o(stall[0]), .iss_ack_o(ack[0]), .busy_o(busy[0]),
        .pend_cnt_o(cnt[0]), .err_o(err[0])
    );

    busy_scoreboard #(.SEL_W(SW), .ZERO_RO(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .iss_vld_i(iss_vld), .iss_dst_i(iss_dst),
        .src1_vld_i(src1_vld), .src1_i(src1),
        .src2_vld_i(src2_vld), .src2_i(src2),
        .wb_vld_i(wb_vld), .wb_dst_i(wb_dst),
        .stall_o(stall[1]), .iss_ack_o(ack[1]), .busy_o(busy[1]),
        .pend_cnt_o(cnt[1]), .err_o(err[1])
    );

    typedef struct {
        bit                 chk;
        logic [1:0]         stall;
        logic [1:0]         ack;
        logic [1:0]         err;
        logic [1:0][NR-1:0] busy;
        logic [1:0][SW:0]   cnt;
    } exp_t;

    exp_t q[$];

    // Reference model: one busy flag per register and a sticky error flag.
    bit m_busy[2][NR];
    bit m_err[2];
    bit m_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int k, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic step(input int r, input int f, input int iv, input int d,
                        input int s1v, input int s1, input int s2v, input int s2,
                        input int wv, input int wd);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r[0]; flush = f[0]; iss_vld = iv[0]; iss_dst = d[SW-1:0];
        src1_vld = s1v[0]; src1 = s1[SW-1:0]; src2_vld = s2v[0]; src2 = s2[SW-1:0];
        wb_vld = wv[0]; wb_dst = wd[SW-1:0];
        e.chk = m_valid;
        for (int k = 0; k < 2; k++) begin
            bit z, st, a;
            int n;
            z  = (k == 1);
            st = (s1v != 0 && m_busy[k][s1]) || (s2v != 0 && m_busy[k][s2]) ||
                 (iv != 0 && m_busy[k][d]);
            a  = (iv != 0) && !st;
            n  = 0;
            for (int i = 0; i < NR; i++) begin
                e.busy[k][i] = m_busy[k][i];
                if (m_busy[k][i]) n++;
            end
            e.stall[k] = st;
            e.ack[k]   = a;
            e.err[k]   = m_err[k];
            e.cnt[k]   = n[SW:0];
            if (r != 0) begin
                for (int i = 0; i < NR; i++) m_busy[k][i] = 1'b0;
                m_err[k] = 1'b0;
            end else if (f != 0) begin
                for (int i = 0; i < NR; i++) m_busy[k][i] = 1'b0;
            end else begin
                if (wv != 0 && !(z && wd == 0)) begin
                    if (m_busy[k][wd]) m_busy[k][wd] = 1'b0;
                    else               m_err[k] = 1'b1;
                end
                if (a && !(z && d == 0)) m_busy[k][d] = 1'b1;
            end
        end
        if (r != 0) m_valid = 1'b1;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    for (int k = 0; k < 2; k++) begin
                        check("stall", k, 8'(stall[k]), 8'(e.stall[k]));
                        check("iss_ack", k, 8'(ack[k]), 8'(e.ack[k]));
                        check("busy", k, busy[k], e.busy[k]);
                        check("pend_cnt", k, 8'(cnt[k]), 8'(e.cnt[k]));
                        check("err", k, 8'(err[k]), 8'(e.err[k]));
                    end
                end
            end
        end
    end

    initial begin
        int wd, tries;
        rst = 1'b1; flush = 1'b0; iss_vld = 1'b0; iss_dst = '0;
        src1_vld = 1'b0; src1 = '0; src2_vld = 1'b0; src2 = '0;
        wb_vld = 1'b0; wb_dst = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 1, 3, 0, 0);

        step(0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0, 0, 1, 5);
        step(0, 0, 1, 1, 1, 5, 0, 0, 0, 0);

        step(0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0, 0, 1, 3);
        idle();

        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0, 0, 1, 6);
        idle();

        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NR; i++) step(0, 0, 1, i, 0, 0, 0, 0, 0, 0);
        idle();
        step(0, 1, 1, 4, 0, 0, 0, 0, 1, 2);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle();

        for (int c = 0; c < 3000; c++) begin
            wd = int'($urandom_range(NR - 1));
            if ($urandom_range(3) != 0) begin
                tries = 0;
                while (!m_busy[0][wd] && tries < 8) begin
                    wd = int'($urandom_range(NR - 1));
                    tries++;
                end
            end
            step(($urandom_range(199) == 0) ? 1 : 0,
                 ($urandom_range(29) == 0) ? 1 : 0,
                 int'($urandom_range(1)), int'($urandom_range(NR - 1)),
                 int'($urandom_range(1)), int'($urandom_range(NR - 1)),
                 int'($urandom_range(1)), int'($urandom_range(NR - 1)),
                 int'($urandom_range(1)), wd);
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
